gif_frame_fetch: RTL and testbench

GIF_FRAME_FETCH -- requirements
Module: gif_frame_fetch

---
 rtl/gif_frame_fetch.sv | 146 ++++++++++++++
 tb/tb_gif_frame_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gif_frame_fetch.sv
// Sprite frame fetcher: maps VGA pixel coordinates to frame-ROM addresses and
// returns sprite colour with 3-cycle latency. Optional macro: GIF_TRANSPARENCY_EN.
module gif_frame_fetch #(
    parameter int          IMG_W     = 160,
    parameter int          IMG_H     = 120,
    parameter int          X0        = 240,
    parameter int          Y0        = 180,
    parameter int          ADDR_W    = 17,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        frame_sel,
    input  logic              frame_changed,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [11:0]       mem_data,
    output logic [11:0]       rgb_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              video_on_out,
    output logic              swap_pulse
);

`ifdef GIF_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    localparam logic [31:0] FRAME_SZ = 32'(IMG_W * IMG_H);

    logic [1:0]        active_frame_q, active_frame_d;
    logic [1:0]        pend_frame_q, pend_frame_d;
    logic              pend_q, pend_d;
    logic              swap_pulse_q, swap_pulse_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_en_q, mem_en_d;
    logic [1:0]        win_q, win_d;
    logic [1:0]        von_q, von_d;
    logic [1:0]        hs_q, hs_d;
    logic [1:0]        vs_q, vs_d;
    logic [11:0]       rgb_out_q, rgb_out_d;
    logic              hsync_out_q, hsync_out_d;
    logic              vsync_out_q, vsync_out_d;
    logic              video_on_out_q, video_on_out_d;

    logic        frame_start, in_win, key_hit;
    logic [31:0] px32, py32, rel_x, rel_y, addr_full;

    always_comb begin
        frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);
        px32  = {22'd0, pix_x};
        py32  = {22'd0, pix_y};
        in_win = video_on
              && (px32 >= 32'(X0)) && (px32 < 32'(X0 + IMG_W))
              && (py32 >= 32'(Y0)) && (py32 < 32'(Y0 + IMG_H));
        rel_x = px32 - 32'(X0);
        rel_y = py32 - 32'(Y0);
        addr_full = 32'(active_frame_q) * FRAME_SZ + rel_y * 32'(IMG_W) + rel_x;

        // Swap only at the top-left pixel so a frame is never torn mid-scan;
        // a request arriving on that same pixel waits for the next frame.
        active_frame_d = active_frame_q;
        pend_frame_d   = pend_frame_q;
        pend_d         = pend_q;
        swap_pulse_d   = 1'b0;
        if (frame_start && pend_q) begin
            active_frame_d = pend_frame_q;
            pend_d         = 1'b0;
            swap_pulse_d   = 1'b1;
        end
        if (frame_changed) begin
            pend_frame_d = frame_sel;
            pend_d       = 1'b1;
        end

        mem_en_d   = in_win;
        mem_addr_d = in_win ? addr_full[ADDR_W-1:0] : '0;

        win_d = {win_q[0], in_win};
        von_d = {von_q[0], video_on};
        hs_d  = {hs_q[0], hsync_in};
        vs_d  = {vs_q[0], vsync_in};

        key_hit = TRANSP_EN && (mem_data == KEY_COLOR);
        if (win_q[1])
            rgb_out_d = key_hit ? BG_COLOR : mem_data;
        else if (von_q[1])
            rgb_out_d = BG_COLOR;
        else
            rgb_out_d = 12'h000;
        hsync_out_d    = hs_q[1];
        vsync_out_d    = vs_q[1];
        video_on_out_d = von_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_frame_q <= '0;
            pend_frame_q   <= '0;
            pend_q         <= 1'b0;
            swap_pulse_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_en_q       <= 1'b0;
            win_q          <= '0;
            von_q          <= '0;
            hs_q           <= '0;
            vs_q           <= '0;
            rgb_out_q      <= '0;
            hsync_out_q    <= 1'b0;
            vsync_out_q    <= 1'b0;
            video_on_out_q <= 1'b0;
        end else begin
            active_frame_q <= active_frame_d;
            pend_frame_q   <= pend_frame_d;
            pend_q         <= pend_d;
            swap_pulse_q   <= swap_pulse_d;
            mem_addr_q     <= mem_addr_d;
            mem_en_q       <= mem_en_d;
            win_q          <= win_d;
            von_q          <= von_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            rgb_out_q      <= rgb_out_d;
            hsync_out_q    <= hsync_out_d;
            vsync_out_q    <= vsync_out_d;
            video_on_out_q <= video_on_out_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_en       = mem_en_q;
    assign rgb_out      = rgb_out_q;
    assign hsync_out    = hsync_out_q;
    assign vsync_out    = vsync_out_q;
    assign video_on_out = video_on_out_q;
    assign swap_pulse   = swap_pulse_q;

endmodule

// File: tb/tb_gif_frame_fetch.sv
// Scoreboard bench for gif_frame_fetch: stimulus pushes expectations, a
// posedge monitor pops them as the DUT produces stage-1 and stage-3 outputs.
module tb_gif_frame_fetch;
    localparam int          IMG_W = 160, IMG_H = 120, X0 = 240, Y0 = 180, ADDR_W = 17;
    localparam logic [11:0] BG    = 12'h123;
    localparam logic [11:0] KEY   = 12'hF0F;
`ifdef GIF_TRANSPARENCY_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic              clk, rst;
    logic [1:0]        frame_sel;
    logic              frame_changed;
    logic [9:0]        pix_x, pix_y;
    logic              video_on, hsync_in, vsync_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [11:0]       mem_data;
    logic [11:0]       rgb_out;
    logic              hsync_out, vsync_out, video_on_out, swap_pulse;

    gif_frame_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(ADDR_W),
                      .BG_COLOR(BG), .KEY_COLOR(KEY)) dut (
        .clk(clk), .rst(rst), .frame_sel(frame_sel), .frame_changed(frame_changed),
        .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_on_out(video_on_out), .swap_pulse(swap_pulse));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[11:0] ^ 12'hABC;
    endfunction

    always @(posedge clk) mem_data <= mem_en ? rom_fn(mem_addr) : 12'h000;

    typedef struct { logic [ADDR_W-1:0] addr; logic en; logic swap; } s1_t;
    typedef struct { logic [11:0] rgb; logic hs; logic vs; logic von; } px_t;

    s1_t s1_q[$];
    px_t px_q[$];
    int  n_checks = 0, n_fail = 0;

    logic [1:0] m_active = 0, m_pend_frame = 0;
    bit         m_pend = 0;

    // Drive one pixel at the falling edge and record what the model expects.
    task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                         input bit fc, input logic [1:0] fs, input bit r);
        s1_t e;
        px_t p;
        bit  win, fstart;
        int  a;
        logic [11:0] d;
        @(negedge clk);
        rst = r; pix_x = 10'(x); pix_y = 10'(y); video_on = von;
        hsync_in = hs; vsync_in = vs; frame_changed = fc; frame_sel = fs;
        if (r) begin
            m_active = 0; m_pend = 0; m_pend_frame = 0;
            e = '{addr: '0, en: 1'b0, swap: 1'b0};
            s1_q.push_back(e);
            px_q.delete();
            p = '{rgb: 12'h000, hs: 1'b0, vs: 1'b0, von: 1'b0};
            repeat (3) px_q.push_back(p);
            return;
        end
        fstart = (x == 0) && (y == 0);
        win = von && x >= X0 && x < X0 + IMG_W && y >= Y0 && y < Y0 + IMG_H;
        a = win ? int'(m_active) * IMG_W * IMG_H + (y - Y0) * IMG_W + (x - X0) : 0;
        e = '{addr: ADDR_W'(a), en: win, swap: fstart && m_pend};
        if (fstart && m_pend) begin m_active = m_pend_frame; m_pend = 0; end
        if (fc) begin m_pend_frame = fs; m_pend = 1; end
        s1_q.push_back(e);
        d = rom_fn(ADDR_W'(a));
        p.rgb = win ? ((TR && d == KEY) ? BG : d) : (von ? BG : 12'h000);
        p.hs = hs; p.vs = vs; p.von = von;
        px_q.push_back(p);
    endtask

    task automatic pix(input int x, input int y);
        drive(x, y, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic req(input int x, input int y, input logic [1:0] fs);
        drive(x, y, 1'b1, 1'b0, 1'b0, 1'b1, fs, 1'b0);
    endtask

    task automatic after_edge;
        @(posedge clk); #2;
    endtask

    s1_t me;
    px_t mp;
    always @(posedge clk) begin
        #1;
        if (s1_q.size() > 0) begin
            me = s1_q.pop_front();
            n_checks++;
            if (mem_addr !== me.addr || mem_en !== me.en || swap_pulse !== me.swap) begin
                n_fail++;
                $display("FAIL stage1 addr/en/swap: got %0d/%0b/%0b expected %0d/%0b/%0b",
                         mem_addr, mem_en, swap_pulse, me.addr, me.en, me.swap);
            end
            if (px_q.size() >= 3) begin
                mp = px_q.pop_front();
                n_checks++;
                if (rgb_out !== mp.rgb || hsync_out !== mp.hs || vsync_out !== mp.vs ||
                    video_on_out !== mp.von) begin
                    n_fail++;
                    $display("FAIL stage3 rgb/hs/vs/von: got %h/%b/%b/%b expected %h/%b/%b/%b",
                             rgb_out, hsync_out, vsync_out, video_on_out,
                             mp.rgb, mp.hs, mp.vs, mp.von);
                end
            end
        end
    end

    task automatic test_reset;
        drive(300, 200, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        drive(300, 200, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        after_edge();
        n_checks++;
        if ({mem_addr, mem_en, rgb_out, hsync_out, vsync_out, video_on_out, swap_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs %h/%b/%h/%b%b%b%b not all zero",
                     mem_addr, mem_en, rgb_out, hsync_out, vsync_out, video_on_out, swap_pulse);
        end
    endtask

    task automatic test_swap;
        req(100, 50, 2'd2);
        pix(240, 180);
        after_edge();
        n_checks++;
        if (mem_addr !== 17'd0) begin
            n_fail++; $display("FAIL swap_hold: mem_addr %0d expected 0", mem_addr);
        end
        pix(0, 0);
        after_edge();
        n_checks++;
        if (swap_pulse !== 1'b1) begin
            n_fail++; $display("FAIL swap_pulse: got %b expected 1", swap_pulse);
        end
        pix(1, 0);
        after_edge();
        n_checks++;
        if (swap_pulse !== 1'b0) begin
            n_fail++; $display("FAIL swap_one_cycle: got %b expected 0", swap_pulse);
        end
        pix(240, 180);
        after_edge();
        n_checks++;
        if (mem_addr !== 17'd38400) begin
            n_fail++; $display("FAIL swap_addr: mem_addr %0d expected 38400", mem_addr);
        end
    endtask

    task automatic test_sweep;
        req(10, 10, 2'd1);
        pix(0, 0);
        pix(241, 181);
        after_edge();
        n_checks++;
        if (mem_addr !== 17'd19361) begin
            n_fail++; $display("FAIL sweep_addr: mem_addr %0d expected 19361", mem_addr);
        end
        pix(400, 180);
        after_edge();
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL sweep_edge_en: mem_en %b expected 0", mem_en);
        end
        pix(401, 180);
        pix(402, 180);
        after_edge();
        n_checks++;
        if (rgb_out !== BG) begin
            n_fail++; $display("FAIL sweep_bg: rgb_out %h expected %h", rgb_out, BG);
        end
        for (int i = 0; i < 8; i++) pix(X0 + IMG_W - 4 + i, Y0 + IMG_H - 1);
    endtask

    task automatic test_latency;
        req(10, 10, 2'd0);
        pix(0, 0);
        drive(240, 180, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        pix(10, 10);
        pix(10, 10);
        after_edge();
        n_checks++;
        if (rgb_out !== 12'hABC || hsync_out !== 1'b1) begin
            n_fail++; $display("FAIL latency: rgb/hs %h/%b expected abc/1", rgb_out, hsync_out);
        end
        pix(10, 10);
        after_edge();
        n_checks++;
        if (hsync_out !== 1'b0) begin
            n_fail++; $display("FAIL hsync_width: got %b expected 0", hsync_out);
        end
    endtask

    task automatic test_simultaneous;
        req(5, 5, 2'd3);
        req(0, 0, 2'd1);
        after_edge();
        n_checks++;
        if (swap_pulse !== 1'b1) begin
            n_fail++; $display("FAIL simul_swap: got %b expected 1", swap_pulse);
        end
        pix(240, 180);
        after_edge();
        n_checks++;
        if (mem_addr !== 17'd57600) begin
            n_fail++; $display("FAIL simul_active3: mem_addr %0d expected 57600", mem_addr);
        end
        pix(0, 0);
        pix(240, 180);
        after_edge();
        n_checks++;
        if (mem_addr !== 17'd19200) begin
            n_fail++; $display("FAIL simul_active1: mem_addr %0d expected 19200", mem_addr);
        end
    endtask

    task automatic test_reset_mid;
        req(20, 20, 2'd2);
        pix(300, 200);
        drive(300, 200, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        after_edge();
        n_checks++;
        if ({mem_addr, mem_en, rgb_out, hsync_out, vsync_out, video_on_out, swap_pulse} !== '0) begin
            n_fail++; $display("FAIL reset_mid: outputs not zero, rgb %h addr %0d", rgb_out, mem_addr);
        end
        pix(301, 200);
        pix(0, 0);
        after_edge();
        n_checks++;
        if (swap_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_swap: got %b expected 0", swap_pulse);
        end
        pix(241, 181);
        pix(242, 181);
        pix(243, 181);
    endtask

    task automatic test_transparency;
        pix(259, 189);
        pix(10, 10);
        pix(10, 10);
        after_edge();
        n_checks++;
        if (rgb_out !== (TR ? BG : KEY)) begin
            n_fail++; $display("FAIL transparency: rgb_out %h expected %h", rgb_out, TR ? BG : KEY);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            int x, y;
            bit fc;
            x  = (i % 40 == 0) ? 0 : 230 + int'($urandom_range(0, 180));
            y  = (i % 40 == 0) ? 0 : 170 + int'($urandom_range(0, 140));
            fc = ($urandom_range(0, 7) == 0);
            drive(x, y, 1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                  fc, 2'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; frame_sel = 2'd0; frame_changed = 1'b0;
        pix_x = '0; pix_y = '0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        test_reset();
        test_swap();
        test_sweep();
        test_latency();
        test_simultaneous();
        test_reset_mid();
        test_transparency();
        test_back_to_back();
        repeat (3) pix(10, 10);
        @(posedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
